umul_seq: RTL and testbench

//  Iterative unsigned shift-add multiplier; the companion of the non-restoring divider pipeline.

---
 rtl/umul_pkg.sv | 16 +
 rtl/umul_seq_if.sv | 13 +
 rtl/umul_step.sv | 22 ++
 rtl/umul_seq.sv | 113 +++++++++++
 tb/tb_umul_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/umul_pkg.sv
// umul_pkg: shared types and helpers for the iterative unsigned multiplier.
//   umul_state_t    : controller states (IDLE accepts, RUN iterates, DONE presents)
//   umul_count_bits : width of the iteration counter for a given width / bits-per-cycle
package umul_pkg;

    typedef enum logic [1:0] {UMUL_IDLE, UMUL_RUN, UMUL_DONE} umul_state_t;

    // The counter runs from width/bpc-1 down to 0; keep at least one bit so a
    // single-iteration configuration still has a legal register.
    function automatic int umul_count_bits(input int width, input int bpc);
        int n;
        n = width / bpc;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/umul_seq_if.sv
// fixedp: clock/reset bundle shared by the fixed-point datapath blocks
// (multiplier, divider).
//   clk     : datapath clock
//   reset_l : asynchronous active-low reset
//   master  : the side that generates clock and reset
//   slave   : the datapath blocks that consume them
interface fixedp;
    logic clk;
    logic reset_l;

    modport master (output clk, output reset_l);
    modport slave  (input  clk, input  reset_l);
endinterface

// File: rtl/umul_step.sv
// umul_step: one combinational shift-add step of the {A,Q} multiplier.
//   m_in   [WIDTH-1:0]   multiplicand M
//   aq_in  [2*WIDTH-1:0] accumulator {A,Q} before the step
//   aq_out [2*WIDTH-1:0] accumulator after: A += Q[0] ? M : 0, then {c,A,Q} >> 1
module umul_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   m_in,
    input  logic [2*WIDTH-1:0] aq_in,
    output logic [2*WIDTH-1:0] aq_out
);

    logic [WIDTH:0] sum;

    // The adder is one bit wider than A; its carry becomes the new MSB of A
    // after the right shift, so nothing is lost.
    always_comb begin
        sum    = {1'b0, aq_in[2*WIDTH-1:WIDTH]} + (aq_in[0] ? {1'b0, m_in} : '0);
        aq_out = {sum, aq_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/umul_seq.sv
// umul_seq: iterative unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// retiring BITS_PER_CYCLE multiplier bits per cycle (WIDTH/BITS_PER_CYCLE
// iterations). BITS_PER_CYCLE must divide WIDTH; WIDTH must be >= 2.
//   h          fixedp.slave  clock and asynchronous active-low reset
//   in_valid   in   operands present
//   in_ready   out  idle, can accept operands
//   a_in       in   multiplicand
//   b_in       in   multiplier
//   out_valid  out  product present (held until out_ready)
//   out_ready  in   consumer accepts product
//   p_out      out  registered product a*b
//   busy       out  high in RUN and DONE
module umul_seq
    import umul_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    fixedp.slave               h,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p_out,
    output logic               busy
);

    localparam int             STEPS    = WIDTH / BITS_PER_CYCLE;
    localparam int             CW       = umul_count_bits(WIDTH, BITS_PER_CYCLE);
    localparam logic [CW-1:0]  CNT_INIT = CW'(STEPS - 1);

    umul_state_t          state, state_nxt;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     m_q;
    logic [2*WIDTH-1:0]   aq_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [2*WIDTH-1:0]   aq_next;

    // Chain of step instances; each link has its own net so the chain is a
    // plain feed-forward path rather than one self-referencing array.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [2*WIDTH-1:0] aq_i;
        logic [2*WIDTH-1:0] aq_o;
        if (i == 0) begin : g_first
            assign aq_i = aq_q;
        end else begin : g_next
            assign aq_i = g_step[i-1].aq_o;
        end
        umul_step #(.WIDTH(WIDTH)) u_step (
            .m_in   (m_q),
            .aq_in  (aq_i),
            .aq_out (aq_o)
        );
    end

    assign aq_next = g_step[BITS_PER_CYCLE-1].aq_o;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            UMUL_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = UMUL_RUN;
            end
            UMUL_RUN: begin
                busy = 1'b1;
                if (count == '0) state_nxt = UMUL_DONE;
            end
            UMUL_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = UMUL_IDLE;
            end
            default: state_nxt = UMUL_IDLE;
        endcase
    end

    always_ff @(posedge h.clk or negedge h.reset_l) begin
        if (!h.reset_l) begin
            state <= UMUL_IDLE;
            count <= '0;
            m_q   <= '0;
            aq_q  <= '0;
            p_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                UMUL_IDLE: begin
                    if (in_valid) begin
                        m_q   <= a_in;
                        aq_q  <= {{WIDTH{1'b0}}, b_in};
                        count <= CNT_INIT;
                    end
                end
                UMUL_RUN: begin
                    aq_q <= aq_next;
                    // Fixed iteration count: zero operands are not short-cut.
                    if (count == '0) p_q <= aq_next;
                    else             count <= count - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign p_out = p_q;

endmodule

// File: tb/tb_umul_seq.sv
// tb_umul_seq: directed and random checks of umul_seq at WIDTH=16 with four
// instances (BITS_PER_CYCLE 1, 2, 4, 16) sharing one clock/reset bundle.
// Expected products are pushed to a queue at each accept and popped at each
// output handshake. Latency is reported as the number of edges from the
// accept edge to the first edge at which the product can be taken.
module tb_umul_seq;

    localparam int W     = 16;
    localparam int NRAND = 600;

    fixedp h ();

    logic           iv   [4];
    logic           ir   [4];
    logic [W-1:0]   a    [4];
    logic [W-1:0]   b    [4];
    logic           ov   [4];
    logic           ordy [4];
    logic [2*W-1:0] p    [4];
    logic           bsy  [4];

    int             total = 0;
    int             bad   = 0;
    logic [2*W-1:0] sbq[$];
    int             n_push;
    int             n_pop;
    int             ir_hi;

    function automatic int bpc_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 4 : 16;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        umul_seq #(.WIDTH(W), .BITS_PER_CYCLE(bpc_of(g))) u_dut (
            .h         (h),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a_in      (a[g]),
            .b_in      (b[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .p_out     (p[g]),
            .busy      (bsy[g])
        );
    end

    initial begin
        h.clk = 1'b0;
        forever #5 h.clk = ~h.clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        int s;
        s = $urandom_range(0, 7);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return W'($urandom);
    endfunction

    // Called just after a falling edge with inputs already set for the coming
    // rising edge; records the handshakes that edge will perform.
    task automatic tick(input int d);
        logic [2*W-1:0] e;
        if (iv[d] && ir[d]) begin
            e = (2*W)'(a[d]) * (2*W)'(b[d]);
            sbq.push_back(e);
            n_push++;
        end
        if (ov[d] && ordy[d]) begin
            if (sbq.size() == 0) chk("sb_underflow", 64'(sbq.size()), 64'd1);
            else begin
                chk("product", p[d], sbq.pop_front());
                n_pop++;
            end
        end
        @(posedge h.clk);
        @(negedge h.clk);
    endtask

    task automatic start_op(input int d, input logic [W-1:0] aa, input logic [W-1:0] bb);
        a[d]  = aa;
        b[d]  = bb;
        iv[d] = 1'b1;
        chk("in_ready_idle", ir[d], 1);
        tick(d);
        iv[d] = 1'b0;
        a[d]  = W'($urandom);
        b[d]  = W'($urandom);
    endtask

    task automatic wait_out(input int d, output int lat);
        int n;
        n     = 0;
        ir_hi = 0;
        while (!ov[d] && n < 100) begin
            if (ir[d]) ir_hi++;
            tick(d);
            n++;
        end
        chk("out_valid_timeout", 64'(ov[d]), 64'd1);
        lat = n + 1;
    endtask

    initial begin
        int lat, lat2, hold_err, cyc;
        n_push = 0;
        n_pop  = 0;
        for (int d = 0; d < 4; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; a[d] = '0; b[d] = '0;
        end
        h.reset_l = 1'b0;
        repeat (2) @(negedge h.clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_in_ready",  ir[d],  1);
            chk("rst_out_valid", ov[d],  0);
            chk("rst_busy",      bsy[d], 0);
            chk("rst_p_out",     p[d],   0);
        end
        h.reset_l = 1'b1;
        @(negedge h.clk);

        // 1: full-scale operands
        ordy[0] = 1'b1;
        start_op(0, 16'hFFFF, 16'hFFFF);
        chk("t1_busy", bsy[0], 1);
        wait_out(0, lat);
        chk("t1_latency", 64'(lat), 64'd17);
        chk("t1_in_ready_low", 64'(ir_hi), 64'd0);
        chk("t1_p", p[0], 32'hFFFE0001);
        tick(0);
        chk("t1_out_valid_fall", ov[0], 0);
        chk("t1_sb_empty", 64'(sbq.size()), 64'd0);

        // 2: zero operand keeps full latency
        start_op(0, 16'h0000, 16'h1234);
        wait_out(0, lat);
        chk("t2_p_zero", p[0], 32'h0);
        tick(0);
        start_op(0, 16'h0001, 16'hABCD);
        wait_out(0, lat2);
        chk("t2_p_one", p[0], 32'h0000ABCD);
        chk("t2_same_latency", 64'(lat2), 64'(lat));
        chk("t2_latency", 64'(lat2), 64'd17);
        tick(0);

        // 3: consumer stall
        ordy[0] = 1'b0;
        start_op(0, 16'h1234, 16'h5678);
        wait_out(0, lat);
        hold_err = 0;
        repeat (10) begin
            tick(0);
            if (ov[0] !== 1'b1 || p[0] !== 32'h06260060 || ir[0] !== 1'b0) hold_err++;
        end
        chk("t3_hold", 64'(hold_err), 64'd0);
        ordy[0] = 1'b1;
        tick(0);
        chk("t3_out_valid_fall", ov[0], 0);
        chk("t3_in_ready", ir[0], 1);
        chk("t3_busy", bsy[0], 0);

        // 4: reset in the middle of RUN
        start_op(0, 16'h0007, 16'h0009);
        repeat (8) tick(0);
        chk("t4_busy_run", bsy[0], 1);
        h.reset_l = 1'b0;
        #1;
        chk("t4_rst_out_valid", ov[0], 0);
        chk("t4_rst_in_ready", ir[0], 1);
        chk("t4_rst_busy", bsy[0], 0);
        sbq.delete();
        @(negedge h.clk);
        h.reset_l = 1'b1;
        start_op(0, 16'd3, 16'd5);
        wait_out(0, lat);
        chk("t4_latency", 64'(lat), 64'd17);
        chk("t4_p", p[0], 32'h0000000F);
        tick(0);

        // 5: four bits per cycle
        ordy[2] = 1'b1;
        start_op(2, 16'h8001, 16'h8001);
        wait_out(2, lat);
        chk("t5_latency", 64'(lat), 64'd5);
        chk("t5_p", p[2], 32'h40010001);
        tick(2);

        // 6: random traffic with random gaps on every configuration
        for (int d = 0; d < 4; d++) begin
            sbq.delete();
            n_push = 0;
            n_pop  = 0;
            cyc    = 0;
            while (n_push < NRAND && cyc < 20000) begin
                iv[d]   = ($urandom_range(0, 2) != 0);
                a[d]    = rnd_op();
                b[d]    = rnd_op();
                ordy[d] = $urandom_range(0, 1) != 0;
                tick(d);
                cyc++;
            end
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
            cyc     = 0;
            while (sbq.size() != 0 && cyc < 100) begin
                tick(d);
                cyc++;
            end
            chk("rand_accepts",   64'(n_push), 64'(NRAND));
            chk("rand_delivered", 64'(n_pop),  64'(n_push));
            chk("rand_sb_empty",  64'(sbq.size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
